// File: rtl/injection_vc_buffer.sv
// injection_vc_buffer: per-VC injection FIFOs behind one VC-plane-multiplexed port pair.
// Optional wormhole framing check is compiled in with `define INJECTION_FRAMING_CHECK_EN.

module injection_vc_lane #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 8,
  parameter int IDENTIFIER_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     full,
  output logic                     empty,
  output logic [DATA_WIDTH-1:0]    head,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      IDENTIFIER_BITS < 1 || IDENTIFIER_BITS > DATA_WIDTH) begin : g_bad_cfg
    $error("injection_vc_lane: bad DEPTH/IDENTIFIER_BITS");
  end

  logic [AW:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   mem_q, mem_d;
  logic                               wr_en;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign occ   = wr_ptr_q - rd_ptr_q;

`ifdef INJECTION_FRAMING_CHECK_EN
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;
  localparam logic [IDENTIFIER_BITS-1:0] T_HEAD = IDENTIFIER_BITS'(1);
  localparam logic [IDENTIFIER_BITS-1:0] T_BODY = IDENTIFIER_BITS'(2);
  localparam logic [IDENTIFIER_BITS-1:0] T_TAIL = IDENTIFIER_BITS'(3);

  logic [0:0]                 state_q, state_d;
  logic                       err_q, err_d, legal;
  logic [IDENTIFIER_BITS-1:0] ftype;

  assign ftype = data_in[DATA_WIDTH-1 -: IDENTIFIER_BITS];

  // Illegal flits are still handshaken so the node never stalls on them; they just vanish.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    legal   = (state_q == IDLE) ? (ftype == T_HEAD) : (ftype == T_BODY || ftype == T_TAIL);
    if (push) begin
      if (legal) begin
        if (ftype == T_HEAD)      state_d = IN_PKT;
        else if (ftype == T_TAIL) state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign wr_en = push && legal;
  assign err   = err_q;
`else
  assign wr_en = push;
  assign err   = 1'b0;
`endif

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_in;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

module injection_vc_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int VC              = 4,
  parameter int DEPTH           = 8,
  parameter int IDENTIFIER_BITS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(VC)-1:0]              vc_sel,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               valid_in,
  output logic                               ready_in,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [VC*($clog2(DEPTH)+1)-1:0]    occupancy,
  output logic [VC-1:0]                      framing_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(VC);

  if (VC < 2) begin : g_bad_vc
    $error("injection_vc_buffer: VC must be >= 2");
  end

  logic [VC-1:0]                  sel_v, push_v, pop_v, full_v, empty_v;
  logic [VC-1:0][DATA_WIDTH-1:0]  head_v;
  logic [VC-1:0][AW:0]            occ_v;

  always_comb begin
    sel_v = '0;
    for (int i = 0; i < VC; i++) sel_v[i] = (vc_sel == SW'(i));
  end

  // Only the selected lane can move; ready_in never looks at valid_in.
  assign push_v = sel_v & {VC{valid_in}}  & ~full_v;
  assign pop_v  = sel_v & {VC{ready_out}} & ~empty_v;

  injection_vc_lane #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DEPTH          (DEPTH),
    .IDENTIFIER_BITS(IDENTIFIER_BITS)
  ) u_lane [VC-1:0] (
    .clk    (clk),
    .rst    (rst),
    .push   (push_v),
    .pop    (pop_v),
    .data_in(data_in),
    .full   (full_v),
    .empty  (empty_v),
    .head   (head_v),
    .occ    (occ_v),
    .err    (framing_error)
  );

  assign ready_in  = !full_v[vc_sel];
  assign valid_out = !empty_v[vc_sel];
  assign data_out  = head_v[vc_sel];
  assign occupancy = occ_v;
endmodule

// File: tb/tb_injection_vc_buffer.sv
// Randomized + directed bench for injection_vc_buffer against a queue-based reference model.
module tb_injection_vc_buffer;
  localparam int DW    = 32;
  localparam int NVC   = 4;
  localparam int DEPTH = 8;
  localparam int IB    = 2;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int SW    = $clog2(NVC);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SW-1:0]     vc_sel = '0;
  logic [DW-1:0]     data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic              ready_out = 1'b0;
  logic [NVC*OW-1:0] occupancy;
  logic [NVC-1:0]    framing_error;

  injection_vc_buffer #(
    .DATA_WIDTH(DW), .VC(NVC), .DEPTH(DEPTH), .IDENTIFIER_BITS(IB)
  ) dut (
    .clk(clk), .rst(rst), .vc_sel(vc_sel), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .occupancy(occupancy), .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: one queue per VC, packet state and sticky error per VC
  logic [DW-1:0] q [NVC][$];
  bit            st    [NVC];
  bit            err_m [NVC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input int v);
    logic [NVC*OW-1:0] eo;
    logic [NVC-1:0]    ee;
    for (int i = 0; i < NVC; i++) begin
      eo[i*OW +: OW] = OW'(q[i].size());
      ee[i]          = err_m[i];
    end
    chk("ready_in",  ready_in,  q[v].size() < DEPTH);
    chk("valid_out", valid_out, q[v].size() != 0);
    if (q[v].size() != 0) chk("data_out", data_out, q[v][0]);
    chk("occupancy", occupancy, eo);
    chk("framing_error", framing_error, ee);
  endtask

  task automatic model_accept(input int v, input logic [DW-1:0] d);
    logic [1:0] t;
    bit legal;
    t     = d[DW-1 -: 2];
    legal = st[v] ? (t == 2'b10 || t == 2'b11) : (t == 2'b01);
    if (legal) begin
      if (t == 2'b01)      st[v] = 1'b1;
      else if (t == 2'b11) st[v] = 1'b0;
    end
`ifdef INJECTION_FRAMING_CHECK_EN
    if (legal) q[v].push_back(d);
    else       err_m[v] = 1'b1;
`else
    q[v].push_back(d);
`endif
  endtask

  // Called at a negedge; checks the combinational view, then applies one clock edge.
  task automatic step(input int v, input bit vi, input logic [DW-1:0] d, input bit ro);
    bit mr, mv;
    vc_sel    = v[SW-1:0];
    valid_in  = vi;
    data_in   = d;
    ready_out = ro;
    #1;
    mr = q[v].size() < DEPTH;
    mv = q[v].size() != 0;
    check_outputs(v);
    @(posedge clk);
    if (mv && ro) void'(q[v].pop_front());
    if (vi && mr) model_accept(v, d);
    @(negedge clk);
  endtask

  task automatic reset_check();
    for (int v = 0; v < NVC; v++) begin
      vc_sel = v[SW-1:0];
      #1;
      chk("rst_ready_in",  ready_in,  1'b1);
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_data_out",  data_out,  '0);
      chk("rst_occupancy", occupancy, '0);
      chk("rst_framing",   framing_error, '0);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    reset_check();
    for (int i = 0; i < NVC; i++) begin
      q[i].delete();
      st[i]    = 1'b0;
      err_m[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] gen_flit(input int v);
    logic [1:0] t;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      t = 2'($urandom_range(0, 3));
    else if (!st[v]) t = 2'b01;
    else             t = (r < 6) ? 2'b10 : 2'b11;
    return {t, 30'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NVC; i++) begin
      st[i] = 1'b0;
      err_m[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset_check();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // three-flit packet on VC2, held, then drained in order
    step(2, 1, 32'h4000_0005, 0);
    step(2, 1, 32'h8000_0001, 0);
    step(2, 1, 32'hC000_0105, 0);
    for (int k = 0; k < 4; k++) step(2, 0, '0, 1);

    // fill VC1, then try a 9th flit with and without a concurrent pop
    step(1, 1, 32'h4000_1000, 0);
    for (int k = 1; k < 8; k++) step(1, 1, 32'h8000_1000 + k, 0);
    step(1, 1, 32'h8000_10FF, 0);
    step(1, 1, 32'h8000_10FE, 1);
    step(1, 0, '0, 0);

    // VC0 at occupancy 4 streaming through pointer wraps
    step(0, 1, 32'h4000_2000, 0);
    for (int k = 1; k < 4; k++) step(0, 1, 32'h8000_2000 + k, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 32'h8000_2100 + k, 1);
    step(0, 1, 32'hC000_2200, 0);

    // body in IDLE on VC3, then a clean head/tail pair
    step(3, 1, 32'h8000_0000, 0);
    step(3, 1, 32'h4000_3000, 0);
    step(3, 1, 32'hC000_3001, 0);
    step(3, 0, '0, 0);

    // randomized traffic over all VCs
    for (int k = 0; k < 400; k++) begin
      int v;
      v = $urandom_range(0, NVC - 1);
      step(v, $urandom_range(0, 3) != 0, gen_flit(v), $urandom_range(0, 2) == 0);
    end

    // reset in the middle of a packet on VC1
    do_reset();
    step(1, 1, 32'h4000_4000, 0);
    step(1, 1, 32'h8000_4001, 0);
    step(1, 1, 32'h8000_4002, 0);
    step(1, 0, '0, 0);
    do_reset();
    step(1, 1, 32'h4000_5000, 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 1);
    step(1, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/injection_vc_buffer.md
# injection_vc_buffer

Per-VC flit buffer at a node's local injection port. It sits between a traffic node's output handshake and the router's local input port. It accepts flits time-multiplexed by the VC plane selector and stores them in independent per-VC FIFOs, decoupling node injection timing from router back-pressure. It presents the buffered flits to the router on the same VC plane schedule. It also checks wormhole packet framing per VC.

## Interface
- DATA_WIDTH, 32, flit width
- VC, 4, number of virtual channels; ≥2
- DEPTH, 8, flits per VC FIFO; power of two, ≥2
- IDENTIFIER_BITS, 2, flit-type field width at the flit MSBs
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- vc_sel  input  $clog2(VC)  active VC plane this cycle, from the VC plane controller
- data_in  input  DATA_WIDTH  flit from the node
- valid_in  input  1  data_in is valid for FIFO[vc_sel]
- ready_in  output  1  FIFO[vc_sel] can accept a flit
- data_out  output  DATA_WIDTH  head flit of FIFO[vc_sel], towards the router
- valid_out  output  1  FIFO[vc_sel] is non-empty
- ready_out  input  1  router accepts data_out
- occupancy  output  VC*($clog2(DEPTH)+1)  flattened per-VC fill level; VC i occupies slice i
- framing_error  output  VC  sticky per-VC protocol-error flags

## Operation
- Flit type comes from data_in[DATA_WIDTH-1 -: IDENTIFIER_BITS]:
  - 2'b01 = head
  - 2'b10 = body
  - 2'b11 = tail
  - 2'b00 = invalid
- Each VC has its own FIFO:
  - read pointer and write pointer, each $clog2(DEPTH)+1 bits with a wrap bit
  - full when the indices are equal and the wrap bits differ
  - empty when both pointers are fully equal
- ready_in = !full[vc_sel]. ready_in is purely a function of vc_sel and state; it has no combinational dependence on valid_in.
- Push into FIFO[vc_sel] when valid_in && ready_in.
- data_out = mem[vc_sel][rd_ptr[vc_sel]]; valid_out = !empty[vc_sel].
- Pop FIFO[vc_sel] when valid_out && ready_out.
- Only one VC is touched per cycle (the vc_sel VC). All other VCs hold.
- Per-VC framing FSM with states IDLE and IN_PKT:
  - head in IDLE → IN_PKT
  - body in IN_PKT → IN_PKT
  - tail in IN_PKT → IDLE
- The framing FSM advances only on accepted flits.
- occupancy[i] = wr_ptr[i] − rd_ptr[i], computed modulo 2·DEPTH; range 0..DEPTH.

## Timing
- Reset values (asynchronous, immediate):
  - all pointers 0
  - all FSMs IDLE
  - framing_error = 0
  - occupancy = 0
  - valid_out = 0, ready_in = 1, data_out = 0 (memory is cleared)
- Latency: a flit pushed at edge N is visible on data_out from after edge N, whenever vc_sel selects that VC. There is no same-cycle bypass from data_in to data_out.
- Full FIFO: ready_in = 0 even if a pop occurs in the same cycle; a flit is never accepted when full.
- Empty FIFO: valid_out = 0; data_out is don't-care.
- Simultaneous push and pop on a non-full, non-empty VC: both happen and occupancy is unchanged.
- Pointer wrap: index bits wrap from DEPTH−1 to 0 and the wrap bit toggles. There is no corruption across wraps.
- A vc_sel change is reflected combinationally on ready_in, valid_out and data_out in the same cycle.
- Reset asserted mid-packet discards all buffered flits and returns every FSM to IDLE.

## Configuration
- INJECTION_FRAMING_CHECK_EN defined:
  - The framing FSM is active.
  - A flit that is invalid, a body or tail arriving in IDLE, or a head arriving in IN_PKT is accepted (ready_in is unchanged) but dropped, not written.
  - Such a flit sets framing_error[vc_sel], which stays set until reset.
  - The FSM state does not change on a dropped flit.
- INJECTION_FRAMING_CHECK_EN undefined:
  - The FSM logic is absent.
  - Every accepted flit is written regardless of type.
  - framing_error is tied to 0.

## Test plan
- Reset then idle, VC=4, DEPTH=8 → ready_in=1, valid_out=0, occupancy=0, framing_error=0 on all VCs.
- vc_sel=2; push head 0x4000_0005, body 0x8000_0001, tail 0xC000_0105; ready_out=0 → occupancy[2]=3, other VCs 0. Then ready_out=1 → the three flits are popped in order over 3 cycles.
- vc_sel=1; push 8 flits with ready_out=0 → ready_in=0 after the 8th. A 9th valid_in is not accepted and occupancy[1] stays 8.
- vc_sel=0; with occupancy 4, hold valid_in=1 and ready_out=1 for 20 cycles → occupancy stays 4, pointers wrap twice, output order equals input order.
- With INJECTION_FRAMING_CHECK_EN: vc_sel=3; push body 0x8000_0000 while IDLE → not stored (occupancy[3]=0), framing_error=4'b1000. Then a head–tail pair → stored normally.
- Push head plus 2 bodies on VC1, assert rst for 1 cycle → occupancy all 0, valid_out=0. A new head is accepted without error.
